// File: rtl/mixer_nch.sv
// N-channel offset-binary voice mixer: folds one channel per clock through a shared
// multiplier using the pairwise non-clipping mix law, with ready/valid on both sides.
module mixer_nch #(
    parameter int W         = 18,
    parameter int NCH       = 8,
    parameter int FULL_TOTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH*W-1:0]   in_samples,
    input  logic [NCH-1:0]     in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_sample,
    output logic               out_clip,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW    = W + 3;
    localparam logic [W-1:0]          H_VAL    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]          MAX_VAL  = {W{1'b1}};
    localparam logic signed [EW-1:0]  F_E      = {3'b001, {W{1'b0}}};
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NCH - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [W-1:0]         acc_q, acc_d;
    logic                 clip_q, clip_d;
    logic [NCH*W-1:0]     samples_q, samples_d;
    logic [NCH-1:0]       mask_q, mask_d;

    logic [W-1:0]         cur_s;
    logic                 cur_m;
    logic [2*W-1:0]       prod;
    logic [W:0]           p_val;
    logic signed [EW-1:0] a_e, b_e, p_e, r_e;
    logic [W-1:0]         mix_val;
    logic                 mix_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= H_VAL;
            clip_q    <= 1'b0;
            samples_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            clip_q    <= clip_d;
            samples_q <= samples_d;
            mask_q    <= mask_d;
        end
    end

    // mix(acc, s) for the current channel; extended signed width keeps 2A+2B-P-F exact
    always_comb begin
        cur_s = '0;
        cur_m = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_s = samples_q[i*W +: W];
                cur_m = mask_q[i];
            end
        end
        prod    = {{W{1'b0}}, acc_q} * {{W{1'b0}}, cur_s};
        p_val   = prod[2*W-1:W-1];
        a_e     = $signed({3'b000, acc_q});
        b_e     = $signed({3'b000, cur_s});
        p_e     = $signed({2'b00, p_val});
        r_e     = (a_e <<< 1) + (b_e <<< 1) - p_e - F_E;
        mix_val = r_e[W-1:0];
        mix_sat = 1'b0;
        if (FULL_TOTH != 0) begin
            if (!acc_q[W-1] && !cur_s[W-1]) begin
                mix_val = p_val[W-1:0];
            end else if (r_e < 0) begin
                mix_val = '0;
                mix_sat = 1'b1;
            end else if (r_e >= F_E) begin
                mix_val = MAX_VAL;
                mix_sat = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        clip_d    = clip_q;
        samples_d = samples_q;
        mask_d    = mask_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_RUN;
                    samples_d = in_samples;
                    mask_d    = in_mask;
                    acc_d     = H_VAL;
                    idx_d     = '0;
                    clip_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (cur_m) begin
                    acc_d  = mix_val;
                    clip_d = clip_q | mix_sat;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) && rst_n;
        out_valid  = (state_q == S_DONE);
        busy       = (state_q == S_RUN) || (state_q == S_DONE);
        out_sample = acc_q;
        out_clip   = clip_q;
    end

endmodule

// File: tb/tb_mixer_nch.sv
// Bench for mixer_nch: saturating and legacy-wrap instances side by side, checked
// against a plain-arithmetic model of the frame fold.
module tb_mixer_nch;

    localparam int W   = 18;
    localparam int NCH = 8;
    localparam longint H  = 64'h20000;
    localparam longint F  = 64'h40000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [NCH*W-1:0]  in_samples;
    logic [NCH-1:0]    in_mask;
    logic              out_ready;
    logic              in_ready1, out_valid1, out_clip1, busy1;
    logic              in_ready0, out_valid0, out_clip0, busy0;
    logic [W-1:0]      out_sample1, out_sample0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mixer_nch #(.W(W), .NCH(NCH), .FULL_TOTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_samples(in_samples), .in_mask(in_mask), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sample(out_sample1), .out_clip(out_clip1), .busy(busy1)
    );

    mixer_nch #(.W(W), .NCH(NCH), .FULL_TOTH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_samples(in_samples), .in_mask(in_mask), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sample(out_sample0), .out_clip(out_clip0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference fold: start at silence, apply the mix law to each enabled channel in order
    task automatic model_frame(input logic [NCH*W-1:0] s, input logic [NCH-1:0] m,
                               input bit full, output logic [W-1:0] res, output logic clip);
        longint acc, a, b, p, r;
        acc  = H;
        clip = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                a = acc;
                b = longint'(s[i*W +: W]);
                p = (a * b) / (F / 2);
                r = 2*a + 2*b - p - F;
                if (full) begin
                    if (a < H && b < H) r = p;
                    else if (r < 0) begin r = 0; clip = 1'b1; end
                    else if (r > F - 1) begin r = F - 1; clip = 1'b1; end
                end else begin
                    r = ((r % F) + F) % F;
                end
                acc = r;
            end
        end
        res = W'(acc);
    endtask

    task automatic send_frame(input logic [NCH*W-1:0] s, input logic [NCH-1:0] m);
        in_samples = s;
        in_mask    = m;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    // Ticks until out_valid rises; returns -1 if it never does within the budget
    task automatic wait_out(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_valid1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [NCH*W-1:0] s,
                                 input logic [NCH-1:0] m);
        logic [W-1:0] e1, e0;
        logic c1, c0;
        int cyc;
        model_frame(s, m, 1'b1, e1, c1);
        model_frame(s, m, 1'b0, e0, c0);
        send_frame(s, m);
        wait_out(cyc);
        tests++;
        if (cyc !== NCH) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, NCH);
        end
        tests++;
        if (out_sample1 !== e1 || out_clip1 !== c1) begin
            fails++;
            $display("FAIL %s sat: got %h clip %b, want %h clip %b", name, out_sample1, out_clip1, e1, c1);
        end
        tests++;
        if (out_sample0 !== e0 || out_clip0 !== 1'b0 || out_valid0 !== 1'b1) begin
            fails++;
            $display("FAIL %s wrap: got %h clip %b valid %b, want %h clip 0 valid 1",
                     name, out_sample0, out_clip0, out_valid0, e0);
        end
        release_out();
        tests++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL %s return_idle: in_ready %b out_valid %b busy %b, want 1 0 0",
                     name, in_ready1, out_valid1, busy1);
        end
    endtask

    function automatic logic [NCH*W-1:0] fill(input logic [W-1:0] v);
        logic [NCH*W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (out_valid1 !== 1'b0 || out_sample1 !== W'(H) || in_ready1 !== 1'b0 ||
            out_clip1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid %b sample %h ready %b clip %b busy %b, want 0 20000 0 0 0",
                     out_valid1, out_sample1, in_ready1, out_clip1, busy1);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready %b/%b, want 1", in_ready1, in_ready0);
        end
    endtask

    task automatic test_identity();
        logic [NCH*W-1:0] s;
        s = fill(W'($urandom));
        s[0 +: W] = 18'h12345;
        run_and_check("identity", s, 8'h01);
        tests++;
        if (out_sample1 !== 18'h12345) begin
            fails++;
            $display("FAIL identity_const: got %h, want 12345", out_sample1);
        end
        run_and_check("mask_zero", s, 8'h00);
        tests++;
        if (out_sample1 !== 18'h20000 || out_clip1 !== 1'b0) begin
            fails++;
            $display("FAIL mask_zero_const: got %h clip %b, want 20000 clip 0", out_sample1, out_clip1);
        end
    endtask

    task automatic test_silence();
        run_and_check("silence", fill(18'h20000), 8'hFF);
        tests++;
        if (out_sample1 !== 18'h20000 || out_clip1 !== 1'b0) begin
            fails++;
            $display("FAIL silence_const: got %h clip %b, want 20000 clip 0", out_sample1, out_clip1);
        end
    endtask

    task automatic test_full_scale();
        run_and_check("full_scale", fill(18'h3FFFF), 8'h03);
        tests++;
        if (out_sample1 !== 18'h3FFFF || out_clip1 !== 1'b1 ||
            out_sample0 !== 18'h00000 || out_clip0 !== 1'b0) begin
            fails++;
            $display("FAIL full_scale_const: got %h/%b wrap %h/%b, want 3ffff/1 wrap 00000/0",
                     out_sample1, out_clip1, out_sample0, out_clip0);
        end
    endtask

    task automatic test_low_branch();
        run_and_check("low_branch", fill(18'h10000), 8'h03);
        tests++;
        if (out_sample1 !== 18'h08000 || out_sample0 !== 18'h38000) begin
            fails++;
            $display("FAIL low_branch_const: got %h wrap %h, want 08000 wrap 38000",
                     out_sample1, out_sample0);
        end
    endtask

    task automatic test_handshake();
        logic [NCH*W-1:0] s;
        logic [W-1:0] e1, held;
        logic c1;
        int cyc;
        int bad = 0;
        s = fill(18'h30000);
        model_frame(s, 8'hA5, 1'b1, e1, c1);
        send_frame(s, 8'hA5);
        wait_out(cyc);
        held = out_sample1;
        in_samples = fill(18'h01234);
        in_mask    = 8'hFF;
        in_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid1 !== 1'b1 || out_sample1 !== held || in_ready1 !== 1'b0) bad++;
        end
        tests++;
        if (cyc !== NCH || held !== e1 || bad != 0) begin
            fails++;
            $display("FAIL stall_hold: latency %0d sample %h unstable %0d, want %0d %h 0",
                     cyc, held, bad, NCH, e1);
        end
        in_valid = 1'b0;
        release_out();
        tests++;
        if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: in_ready %b busy %b, want 1 0", in_ready1, busy1);
        end
    endtask

    task automatic test_reset_midrun();
        int seen = 0;
        send_frame(fill(18'h3FFFF), 8'hFF);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        tests++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || out_sample1 !== 18'h20000 || out_clip1 !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: busy %b ready %b sample %h clip %b, want 0 0 20000 0",
                     busy1, in_ready1, out_sample1, out_clip1);
        end
        rst_n = 1'b1;
        for (int k = 0; k < NCH + 4; k++) begin
            tick();
            if (out_valid1 || out_valid0 || busy1) seen++;
        end
        tests++;
        if (seen != 0 || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL midrun_discard: stray activity %0d in_ready %b, want 0 1", seen, in_ready1);
        end
    endtask

    task automatic test_random();
        logic [NCH*W-1:0] s;
        logic [NCH-1:0] m;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NCH; i++) begin
                case ($urandom_range(0, 5))
                    0: s[i*W +: W] = '0;
                    1: s[i*W +: W] = 18'h3FFFF;
                    2: s[i*W +: W] = 18'h20000;
                    default: s[i*W +: W] = W'($urandom);
                endcase
            end
            m = NCH'($urandom);
            run_and_check("random", s, m);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_samples = '0;
        in_mask    = '0;
        out_ready  = 1'b0;
        #1;
        tests++;
        if (in_ready1 !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_reset: got %b, want 0", in_ready1);
        end
        test_reset();
        test_identity();
        test_silence();
        test_full_scale();
        test_low_branch();
        test_handshake();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
